// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
// The master side issues operands with start; the slave side returns busy/done and the result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one full-adder cell LSB-first over WIDTH cycles
// and publishes {cout,sum} = a + b + cin with a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] sha_r, sha_s;
    logic [WIDTH-1:0] shb_r, shb_s;
    logic [WIDTH-1:0] psum_r, psum_s;
    logic [WIDTH-1:0] sum_r, sum_s;
    logic             carry_r, carry_s;
    logic             cout_r, cout_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             fa_bit_s;
    logic             fa_cy_s;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Next-state, datapath and output decode; the single FA cell sees the operand LSBs.
    always_comb begin
        state_s  = state_r;
        sha_s    = sha_r;
        shb_s    = shb_r;
        psum_s   = psum_r;
        sum_s    = sum_r;
        carry_s  = carry_r;
        cout_s   = cout_r;
        cnt_s    = cnt_r;
        fa_bit_s = fa_sum(sha_r[0], shb_r[0], carry_r);
        fa_cy_s  = fa_carry(sha_r[0], shb_r[0], carry_r);

        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_s = S_ADD;
                    sha_s   = bus.a;
                    shb_s   = bus.b;
                    carry_s = bus.cin;
                    psum_s  = {WIDTH{1'b0}};
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ADD: begin
                sha_s   = sha_r >> 1;
                shb_s   = shb_r >> 1;
                carry_s = fa_cy_s;
                // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                psum_s  = (psum_r >> 1) | (WIDTH'(fa_bit_s) << (WIDTH - 1));
                cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_r == LAST_BIT) begin
                    sum_s   = psum_s;
                    cout_s  = fa_cy_s;
                    state_s = S_DONE;
                end else begin
                    state_s = S_ADD;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_DONE);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand shifters, carry, counter and registered outputs; reset aborts any add in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sha_r   <= {WIDTH{1'b0}};
            shb_r   <= {WIDTH{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            sha_r   <= sha_s;
            shb_r   <= shb_s;
            psum_r  <= psum_s;
            sum_r   <= sum_s;
            carry_r <= carry_s;
            cout_r  <= cout_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1 against an
// arithmetic reference ({cout,sum} = a + b + cin) with cycle-exact busy/done timing.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] held_sum8;
    logic       held_cout8;
    logic       held_sum1;
    logic       held_cout1;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with dut8 idle; returns at the negedge after the cycle in which
    // the DUT is idle again, so the next call is accepted WIDTH+2 cycles after this one.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit inject);
        logic [8:0] exp_v;
        exp_v = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        @(posedge clk);
        @(negedge clk);
        bus8.a   = 8'($urandom);
        bus8.b   = 8'($urandom);
        bus8.cin = 1'($urandom);
        for (int k = 0; k <= 9; k++) begin
            bus8.start = (inject && k == 2) ? 1'b1 : 1'b0;
            if (inject && k == 2) bus8.a = 8'h11;
            if (k == 8) begin
                held_sum8  = exp_v[7:0];
                held_cout8 = exp_v[8];
            end
            check("busy8", {63'd0, bus8.busy}, {63'd0, (k <= 8)});
            check("done8", {63'd0, bus8.done}, {63'd0, (k == 8)});
            check("sum8",  {56'd0, bus8.sum},  {56'd0, held_sum8});
            check("cout8", {63'd0, bus8.cout}, {63'd0, held_cout8});
            if (k < 9) @(negedge clk);
        end
        bus8.start = 1'b0;
    endtask

    initial begin
        logic [2:0]  v3;
        logic [1:0]  exp1;
        held_sum8  = 8'd0;
        held_cout8 = 1'b0;
        held_sum1  = 1'b0;
        held_cout1 = 1'b0;
        bus8.start = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0;
        reset = 1'b1;

        // Power-on reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, bus8.busy}, 64'd0);
        check("rst_done", {63'd0, bus8.done}, 64'd0);
        check("rst_sum",  {56'd0, bus8.sum},  64'd0);
        check("rst_cout", {63'd0, bus8.cout}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed sums and carry ripple, back-to-back
        op8(8'h3C, 8'h42, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        op8(8'hA5, 8'h5A, 1'b1, 1'b0);
        op8(8'h00, 8'h00, 1'b0, 1'b0);

        // Start while busy is ignored; following op proves nothing was queued
        op8(8'h12, 8'h34, 1'b1, 1'b1);
        op8(8'h80, 8'h81, 1'b0, 1'b0);

        // Abort mid-add with an asynchronous reset between clock edges
        bus8.start = 1'b1; bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, bus8.busy}, 64'd0);
        check("abort_done", {63'd0, bus8.done}, 64'd0);
        check("abort_sum",  {56'd0, bus8.sum},  64'd0);
        check("abort_cout", {63'd0, bus8.cout}, 64'd0);
        held_sum8  = 8'd0;
        held_cout8 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_abort_done", {63'd0, bus8.done}, 64'd0);
            check("post_abort_busy", {63'd0, bus8.busy}, 64'd0);
        end
        op8(8'h01, 8'h01, 1'b0, 1'b0);

        // Randomized operands, occasionally with a stray start during ADD
        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        // WIDTH=1: full-adder truth table, done two cycles after each start
        for (int v = 0; v < 8; v++) begin
            v3 = 3'(v);
            exp1 = 2'(v3[2]) + 2'(v3[1]) + 2'(v3[0]);
            bus1.start = 1'b1;
            bus1.a     = v3[2];
            bus1.b     = v3[1];
            bus1.cin   = v3[0];
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            for (int k = 0; k <= 2; k++) begin
                if (k == 1) begin
                    held_sum1  = exp1[0];
                    held_cout1 = exp1[1];
                end
                check("busy1", {63'd0, bus1.busy}, {63'd0, (k <= 1)});
                check("done1", {63'd0, bus1.done}, {63'd0, (k == 1)});
                check("sum1",  {63'd0, bus1.sum},  {63'd0, held_sum1});
                check("cout1", {63'd0, bus1.cout}, {63'd0, held_cout1});
                if (k < 2) @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: sequences a single 1-bit full adder cell over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in.
- Sits between a requester (start/done handshake) and the shared 1-bit full-adder datapath.
- Holds operand shift registers, the carry flip-flop and the result register.
- Trades area (one FA cell) for latency (WIDTH+1 cycles).

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk    input   1      rising-edge clock
reset  input   1      asynchronous, active-high reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  operand A; captured on accepted start
b      input   WIDTH  operand B; captured on accepted start
cin    input   1      carry-in; captured on accepted start
busy   output  1      high in ADD and DONE states
done   output  1      one-cycle pulse: sum/cout valid
sum    output  WIDTH  registered result; held until the next result is written
cout   output  1      registered carry-out; held with sum

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry FF and bit counter are also cleared.
  - An operation in flight is aborted; no done pulse is produced.
- States:
  - IDLE: busy=0, done=0.
    - start=1 at an edge: load a, b into shift registers, load cin into the carry FF, counter=0, go to ADD.
    - start=0: stay in IDLE.
  - ADD: busy=1.
    - Each edge: FA inputs are shA[0], shB[0] and the carry FF.
    - FA sum bit is shifted into the MSB of a partial-sum register; shA and shB shift right by 1; carry FF takes the FA carry; counter increments.
    - The edge where counter reaches WIDTH-1: write the completed partial sum to sum and the final carry to cout, then go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle; next edge goes to IDLE.
- Latency:
  - start accepted at edge 0; edges 1..WIDTH perform bit additions.
  - done is high in the cycle after edge WIDTH, i.e. WIDTH+1 cycles after acceptance.
  - Back-to-back throughput is one result per WIDTH+2 cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, no overflow flag.
- FA cell: sum = x^y^c; carry = (x&y)|(x&c)|(y&c).
- start while busy (ADD or DONE): ignored, no queuing; a/b/cin changes during ADD have no effect.
- sum/cout change only on the write edge; they never show partial values.
- WIDTH=1: a single ADD cycle, then DONE.
- Counter width is clog2(WIDTH+1); it must not wrap before WIDTH.

Test Plan:
- Reset: assert reset mid-cycle with no clock edge -> busy=0, done=0, sum=0x00, cout=0 immediately. Deassert -> IDLE.
- WIDTH=8, a=0x3C, b=0x42, cin=0, start pulse -> done high exactly 9 cycles after the start edge; sum=0x7E, cout=0; busy high for 9 cycles.
- WIDTH=8 carry ripple:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
  - a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
- Start while busy: second start with a=0x11 at cycle 3 of ADD -> ignored; done fires once with the first result; sum stays stable until the next accepted operation completes.
- Reset at cycle 4 of ADD -> state IDLE, no done pulse, sum=0, cout=0. New start afterwards with a=0x01, b=0x01 -> sum=0x02, cout=0.
- WIDTH=1: all 8 {a,b,cin} combinations, 000 to 111 -> {cout,sum} follows the full-adder truth table (00,01,01,10,01,10,10,11); done 2 cycles after each start.
